player_flash_fx: RTL

Parametrised player-sprite colour effect stage between the player bitmap and the object mux. It replaces the old fixed invert-to-white wrapper. On a trigger pulse it applies a selectable colour effect to opaque player pixels for a programmable number of frames, optionally blinking. A level-hold input gives the old steady-invert behaviour. The pixel path is registered with the drawing request realigned, so it slots into the pipeline as a one-cycle stage.

---
 rtl/player_flash_fx_if.sv | 23 ++
 rtl/player_flash_fx.sv | 106 ++++++++++
 2 files changed

// File: rtl/player_flash_fx_if.sv
// Pixel-path and effect-control bundle for the player flash effect stage.
// The master drives the pixel and control inputs. The slave is the effect stage.
interface player_flash_fx_if;
    logic       startOfFrame;
    logic [7:0] RGBin;
    logic       drawingRequestIn;
    logic       trigger;
    logic [1:0] mode;
    logic       hold_invert;
    logic [7:0] RGBout;
    logic       drawingRequestOut;
    logic       effect_active;

    modport master (
        output startOfFrame, RGBin, drawingRequestIn, trigger, mode, hold_invert,
        input  RGBout, drawingRequestOut, effect_active
    );

    modport slave (
        input  startOfFrame, RGBin, drawingRequestIn, trigger, mode, hold_invert,
        output RGBout, drawingRequestOut, effect_active
    );
endinterface

// File: rtl/player_flash_fx.sv
// One-cycle player-sprite colour effect stage: a timed, optionally blinking effect
// started by a trigger, plus a level-held steady invert.
//
//   state  | meaning
//   IDLE   | no timed effect; only hold_invert can alter pixels
//   ACTIVE | timed effect running; frames_left counts remaining frames
module player_flash_fx #(
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'h00,
    parameter logic [7:0] FLASH_COLOR          = 8'hFF,
    parameter logic [7:0] TINT_MASK            = 8'hE0,
    parameter int         DURATION_FRAMES      = 60,
    parameter int         BLINK_FRAMES         = 4
) (
    input  logic             clk,
    input  logic             reset,
    player_flash_fx_if.slave px
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [7:0] DURATION_LOAD = 8'(DURATION_FRAMES);
    localparam logic [7:0] BLINK_LAST    = 8'(BLINK_FRAMES - 1);
    localparam bit         BLINK_EN      = (BLINK_FRAMES != 0);

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] frames_left_q, frames_left_d;
    logic [7:0] phase_cnt_q, phase_cnt_d;
    logic       blink_on_q, blink_on_d;
    logic [7:0] rgb_out_q, rgb_out_d;
    logic       req_out_q, req_out_d;
    logic [7:0] frames_dec;
    logic       effect_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mode_q        <= 2'd0;
            frames_left_q <= 8'd0;
            phase_cnt_q   <= 8'd0;
            blink_on_q    <= 1'b0;
            rgb_out_q     <= 8'd0;
            req_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            frames_left_q <= frames_left_d;
            phase_cnt_q   <= phase_cnt_d;
            blink_on_q    <= blink_on_d;
            rgb_out_q     <= rgb_out_d;
            req_out_q     <= req_out_d;
        end
    end

    // Trigger takes priority over a coincident startOfFrame, so that frame is not counted.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        frames_left_d = frames_left_q;
        phase_cnt_d   = phase_cnt_q;
        blink_on_d    = blink_on_q;
        frames_dec    = frames_left_q - 8'd1;
        if (px.trigger) begin
            state_d       = ACTIVE;
            mode_d        = px.mode;
            frames_left_d = DURATION_LOAD;
            phase_cnt_d   = 8'd0;
            blink_on_d    = 1'b1;
        end else if (state_q == ACTIVE && px.startOfFrame) begin
            frames_left_d = frames_dec;
            if (frames_dec == 8'd0) begin
                state_d    = IDLE;
                blink_on_d = 1'b0;
            end else if (BLINK_EN) begin
                if (phase_cnt_q == BLINK_LAST) begin
                    phase_cnt_d = 8'd0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    phase_cnt_d = phase_cnt_q + 8'd1;
                end
            end
        end
    end

    // Transparency is judged on the incoming pixel, so an inverted 8'hFF still goes out.
    always_comb begin
        effect_en = px.drawingRequestIn && (px.RGBin != TRANSPARENT_ENCODING) &&
                    (px.hold_invert || (state_q == ACTIVE && blink_on_q));
        rgb_out_d = px.RGBin;
        req_out_d = px.drawingRequestIn;
        if (effect_en) begin
            if (px.hold_invert) begin
                rgb_out_d = ~px.RGBin;
            end else begin
                case (mode_q)
                    2'd1:    rgb_out_d = ~px.RGBin;
                    2'd2:    rgb_out_d = px.RGBin | TINT_MASK;
                    default: rgb_out_d = FLASH_COLOR;
                endcase
            end
        end
    end

    assign px.RGBout            = rgb_out_q;
    assign px.drawingRequestOut = req_out_q;
    assign px.effect_active     = (state_q == ACTIVE);
endmodule
